// File: rtl/lexicode_pkg.sv
// Shared lexicode definitions: decoder FSM encoding, popcount and correction radius.
// The generator imports this package too.
package lexicode_pkg;

    typedef enum logic [1:0] {StIdle, StScan, StLast, StOut} dec_state_e;

    localparam int unsigned PopW = 64;

    // Callers zero-extend their N-bit word to PopW before calling.
    function automatic int unsigned popcount(input logic [PopW-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < PopW; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

    function automatic int unsigned radius(input int unsigned min_hd);
        int unsigned m;
        m = (min_hd == 0) ? 1 : min_hd;
        return (m - 1) >> 1;
    endfunction

endpackage

// File: rtl/lexicode_nd_decoder_if.sv
// Codebook load, received-word, and decode-result channels of the lexicode decoder.
interface lexicode_nd_decoder_if #(
    parameter int unsigned N     = 3,
    parameter int unsigned DEPTH = 1024
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned HD_W   = $clog2(N + 1);

    logic [HD_W-1:0]   min_hd;
    logic              clr;
    logic              cw_valid;
    logic [N-1:0]      cw_data;
    logic              cw_ready;
    logic              rx_valid;
    logic [N-1:0]      rx_data;
    logic              rx_ready;
    logic              dec_valid;
    logic              dec_ready;
    logic [ADDR_W-1:0] dec_index;
    logic [N-1:0]      dec_code;
    logic [HD_W-1:0]   dec_dist;
    logic              dec_err;
    logic [ADDR_W:0]   cb_len;
    logic              cb_ovf;

    modport master (
        output min_hd, clr, cw_valid, cw_data, rx_valid, rx_data, dec_ready,
        input  cw_ready, rx_ready, dec_valid, dec_index, dec_code, dec_dist, dec_err,
               cb_len, cb_ovf
    );

    modport slave (
        input  min_hd, clr, cw_valid, cw_data, rx_valid, rx_data, dec_ready,
        output cw_ready, rx_ready, dec_valid, dec_index, dec_code, dec_dist, dec_err,
               cb_len, cb_ovf
    );

endinterface

// File: rtl/lexicode_cb_ram.sv
// Codebook store: one write port, one synchronous read port, read latency 1.
module lexicode_cb_ram #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lexicode_nd_decoder.sv
// Minimum-distance decoder: stores a lexicode codebook and maps each received word to the
// nearest stored codeword (lowest index wins ties), flagging words beyond the correction radius.
module lexicode_nd_decoder
    import lexicode_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned DEPTH = 1024
) (
    input logic                 clk,
    input logic                 rst,
    lexicode_nd_decoder_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned HD_W   = $clog2(N + 1);
    localparam int unsigned LEN_W  = ADDR_W + 1;

    dec_state_e        state_q, state_d;
    logic [LEN_W-1:0]  cb_len_q, cb_len_d, scan_len_q, scan_len_d;
    logic              cb_ovf_q, cb_ovf_d;
    logic [N-1:0]      rx_q, rx_d;
    logic [HD_W-1:0]   min_hd_q, min_hd_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, cmp_idx_q, cmp_idx_d;
    logic              cmp_en_q, cmp_en_d;
    logic [HD_W-1:0]   best_dist_q, best_dist_d;
    logic [ADDR_W-1:0] best_index_q, best_index_d;
    logic [N-1:0]      best_code_q, best_code_d;
    logic [ADDR_W-1:0] dec_index_q, dec_index_d;
    logic [N-1:0]      dec_code_q, dec_code_d;
    logic [HD_W-1:0]   dec_dist_q, dec_dist_d;
    logic              dec_err_q, dec_err_d;

    logic              ram_we, ram_re;
    logic [N-1:0]      ram_rdata;
    logic [HD_W-1:0]   cand_dist, nxt_dist, radius_w;
    logic [ADDR_W-1:0] nxt_index;
    logic [N-1:0]      nxt_code;
    logic              take;

    lexicode_cb_ram #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_cb_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cb_len_q[ADDR_W-1:0]),
        .wdata (bus.cw_data),
        .re    (ram_re),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

    // Index 0 is always taken so a codeword at the maximum distance is still reported.
    assign cand_dist = HD_W'(popcount(PopW'(ram_rdata ^ rx_q)));
    assign take      = cmp_en_q && ((cmp_idx_q == '0) || (cand_dist < best_dist_q));
    assign nxt_dist  = take ? cand_dist : best_dist_q;
    assign nxt_index = take ? cmp_idx_q : best_index_q;
    assign nxt_code  = take ? ram_rdata : best_code_q;
    assign radius_w  = HD_W'(radius(32'(min_hd_q)));

    assign bus.cw_ready  = (state_q == StIdle);
    assign bus.rx_ready  = (state_q == StIdle);
    assign bus.dec_valid = (state_q == StOut);
    assign bus.dec_index = dec_index_q;
    assign bus.dec_code  = dec_code_q;
    assign bus.dec_dist  = dec_dist_q;
    assign bus.dec_err   = dec_err_q;
    assign bus.cb_len    = cb_len_q;
    assign bus.cb_ovf    = cb_ovf_q;

    always_comb begin
        state_d      = state_q;
        cb_len_d     = cb_len_q;
        scan_len_d   = scan_len_q;
        cb_ovf_d     = cb_ovf_q;
        rx_d         = rx_q;
        min_hd_d     = min_hd_q;
        rd_addr_d    = rd_addr_q;
        cmp_idx_d    = cmp_idx_q;
        cmp_en_d     = cmp_en_q;
        best_dist_d  = best_dist_q;
        best_index_d = best_index_q;
        best_code_d  = best_code_q;
        dec_index_d  = dec_index_q;
        dec_code_d   = dec_code_q;
        dec_dist_d   = dec_dist_q;
        dec_err_d    = dec_err_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.clr) begin
                    cb_len_d = '0;
                    cb_ovf_d = 1'b0;
                end else if (bus.cw_valid) begin
                    if (cb_len_q == LEN_W'(DEPTH)) begin
                        cb_ovf_d = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        cb_len_d = cb_len_q + LEN_W'(1);
                    end
                end
                if (bus.rx_valid) begin
                    rx_d         = bus.rx_data;
                    min_hd_d     = bus.min_hd;
                    scan_len_d   = cb_len_q;
                    rd_addr_d    = '0;
                    cmp_en_d     = 1'b0;
                    best_dist_d  = '1;
                    best_index_d = '0;
                    best_code_d  = '0;
                    if (cb_len_q == '0) begin
                        dec_index_d = '0;
                        dec_code_d  = '0;
                        dec_dist_d  = '0;
                        dec_err_d   = 1'b1;
                        state_d     = StOut;
                    end else begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                ram_re       = 1'b1;
                cmp_en_d     = 1'b1;
                cmp_idx_d    = rd_addr_q;
                rd_addr_d    = rd_addr_q + ADDR_W'(1);
                best_dist_d  = nxt_dist;
                best_index_d = nxt_index;
                best_code_d  = nxt_code;
                if ({1'b0, rd_addr_q} == scan_len_q - LEN_W'(1)) begin
                    state_d = StLast;
                end
            end
            StLast: begin
                cmp_en_d    = 1'b0;
                dec_index_d = nxt_index;
                dec_code_d  = nxt_code;
                dec_dist_d  = nxt_dist;
                dec_err_d   = (nxt_dist > radius_w);
                state_d     = StOut;
            end
            StOut: begin
                if (bus.dec_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cb_len_q     <= '0;
            scan_len_q   <= '0;
            cb_ovf_q     <= 1'b0;
            rx_q         <= '0;
            min_hd_q     <= '0;
            rd_addr_q    <= '0;
            cmp_idx_q    <= '0;
            cmp_en_q     <= 1'b0;
            best_dist_q  <= '1;
            best_index_q <= '0;
            best_code_q  <= '0;
            dec_index_q  <= '0;
            dec_code_q   <= '0;
            dec_dist_q   <= '0;
            dec_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cb_len_q     <= cb_len_d;
            scan_len_q   <= scan_len_d;
            cb_ovf_q     <= cb_ovf_d;
            rx_q         <= rx_d;
            min_hd_q     <= min_hd_d;
            rd_addr_q    <= rd_addr_d;
            cmp_idx_q    <= cmp_idx_d;
            cmp_en_q     <= cmp_en_d;
            best_dist_q  <= best_dist_d;
            best_index_q <= best_index_d;
            best_code_q  <= best_code_d;
            dec_index_q  <= dec_index_d;
            dec_code_q   <= dec_code_d;
            dec_dist_q   <= dec_dist_d;
            dec_err_q    <= dec_err_d;
        end
    end

endmodule

// File: tb/tb_lexicode_nd_decoder.sv
// Directed bench for lexicode_nd_decoder with N=3, DEPTH=4 and hand-computed expectations.
module tb_lexicode_nd_decoder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    lexicode_nd_decoder_if #(.N(3), .DEPTH(4)) bus ();

    lexicode_nd_decoder #(
        .N     (3),
        .DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cw(input logic [2:0] w);
        bus.cw_valid = 1'b1;
        bus.cw_data  = w;
        step();
        bus.cw_valid = 1'b0;
    endtask

    // Issues one rx word, waits for the result, optionally stalls dec_ready, then consumes it.
    task automatic decode(input string tag, input logic [2:0] rx, input logic [1:0] mhd,
                          input int len, input logic [1:0] e_idx, input logic [2:0] e_code,
                          input logic [1:0] e_dist, input logic e_err, input int hold);
        int waited;
        bus.rx_valid = 1'b1;
        bus.rx_data  = rx;
        bus.min_hd   = mhd;
        step();
        bus.rx_valid = 1'b0;
        bus.cw_valid = 1'b0;
        waited = 0;
        while (!bus.dec_valid && waited < 50) begin
            step();
            waited++;
        end
        check_eq({tag, ":lat"}, 32'(waited), 32'((len == 0) ? 0 : len + 1));
        check_eq({tag, ":idx"}, 32'(bus.dec_index), 32'(e_idx));
        check_eq({tag, ":code"}, 32'(bus.dec_code), 32'(e_code));
        check_eq({tag, ":dist"}, 32'(bus.dec_dist), 32'(e_dist));
        check_eq({tag, ":err"}, 32'(bus.dec_err), 32'(e_err));
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq({tag, ":hold"},
                     32'({bus.dec_valid, bus.dec_index, bus.dec_code, bus.dec_dist, bus.dec_err}),
                     32'({1'b1, e_idx, e_code, e_dist, e_err}));
        end
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        check_eq({tag, ":done"}, 32'({bus.dec_valid, bus.rx_ready}), 32'(2'b01));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.min_hd    = '0;
        bus.clr       = 1'b0;
        bus.cw_valid  = 1'b0;
        bus.cw_data   = '0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.dec_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_len", 32'(bus.cb_len), 32'(0));
        check_eq("rst_flags", 32'({bus.cb_ovf, bus.dec_valid, bus.dec_err}), 32'(0));
        check_eq("rst_out", 32'({bus.dec_index, bus.dec_code, bus.dec_dist}), 32'(0));
        check_eq("rst_ready", 32'({bus.cw_ready, bus.rx_ready}), 32'(2'b11));

        // min_hd=2 codebook
        load_cw(3'b000);
        load_cw(3'b011);
        load_cw(3'b101);
        load_cw(3'b110);
        check_eq("len4", 32'(bus.cb_len), 32'(4));
        decode("exact", 3'b101, 2'd2, 4, 2'd2, 3'b101, 2'd0, 1'b0, 0);
        decode("tie", 3'b111, 2'd2, 4, 2'd1, 3'b011, 2'd1, 1'b1, 0);

        // Overflow: dropped word must not land in mem[0]
        load_cw(3'b111);
        check_eq("ovf", 32'(bus.cb_ovf), 32'(1));
        check_eq("ovf_len", 32'(bus.cb_len), 32'(4));
        decode("ovf_hold", 3'b111, 2'd2, 4, 2'd1, 3'b011, 2'd1, 1'b1, 5);

        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        check_eq("clr", 32'({bus.cb_len, bus.cb_ovf}), 32'(0));
        decode("empty", 3'b010, 2'd2, 0, 2'd0, 3'b000, 2'd0, 1'b1, 0);

        // min_hd=3 repetition code
        load_cw(3'b000);
        load_cw(3'b111);
        decode("rep0", 3'b001, 2'd3, 2, 2'd0, 3'b000, 2'd1, 1'b0, 0);
        decode("rep1", 3'b110, 2'd3, 2, 2'd1, 3'b111, 2'd1, 1'b0, 0);

        // Coincident cw/rx: scan sees the pre-write length of 2
        bus.cw_valid = 1'b1;
        bus.cw_data  = 3'b011;
        decode("coinc", 3'b011, 2'd3, 2, 2'd1, 3'b111, 2'd1, 1'b0, 0);
        check_eq("coinc_len", 32'(bus.cb_len), 32'(3));

        // Reset in the middle of a scan
        bus.rx_valid = 1'b1;
        bus.rx_data  = 3'b100;
        step();
        bus.rx_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mrst", 32'({bus.dec_valid, bus.cb_len, bus.rx_ready}), 32'({1'b0, 3'd0, 1'b1}));
        decode("post_rst", 3'b101, 2'd3, 0, 2'd0, 3'b000, 2'd0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
